data_mem_param: RTL and testbench
=================================

DATA_MEM_PARAM -- requirements
Module: data_mem_param

Interface
REQ-001 Parameter DATA_W, default 32: data word width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter DEPTH, default 32: number of words; SHALL be a power of two and at least 2.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; SHALL be aligned to DEPTH*DATA_W/8.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block accepts request this cycle.
REQ-008 req_write  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  DATA_W  write data.
REQ-011 req_be  input  DATA_W/8  byte write enables; bit i covers req_wdata[8i+7:8i].
REQ-012 resp_valid  output  1  response present.
REQ-013 resp_ready  input  1  consumer takes response this cycle.
REQ-014 resp_rdata  output  DATA_W  read data; zero for writes and errors.
REQ-015 resp_err  output  2  status code: OK, MISALIGNED or DECODE_MISS.

Function
REQ-016 Request accepted when req_valid and req_ready are both 1 at a rising edge (handshake).
REQ-017 Address split: OFS = log2(DATA_W/8) low bits are the byte offset; the next log2(DEPTH) bits are the word index; the upper bits form the select field.
REQ-018 Decode hit when req_addr minus the index/offset bits equals BASE_ADDR's upper bits; otherwise status DECODE_MISS.
REQ-019 Nonzero byte offset gives status MISALIGNED; MISALIGNED takes priority over DECODE_MISS.
REQ-020 Accepted write with status OK updates only the enabled bytes of the indexed word at that edge; req_be all-zero is a legal no-op returning OK.
REQ-021 Writes with error status do not modify storage.
REQ-022 Accepted read with status OK returns the indexed word as stored before that edge.
REQ-023 Every accepted request produces exactly one response; latency is one cycle, so resp_valid rises at the edge following acceptance.
REQ-024 Response register: two states, EMPTY and FULL. EMPTY->FULL on accept; FULL->EMPTY on resp_ready with no new accept; FULL->FULL on resp_ready together with a new accept (back-to-back).
REQ-025 req_ready = (state EMPTY) or resp_ready; combinational from resp_ready, with no path from req_valid.
REQ-026 While FULL and resp_ready=0, resp_valid, resp_rdata and resp_err are held stable.
REQ-027 A read accepted in the cycle after a write to the same word returns the newly written bytes.
REQ-028 Responses are delivered in acceptance order; no reordering.

Reset
REQ-029 While reset_n=0: state EMPTY, resp_valid=0, resp_rdata=0, resp_err=OK, req_ready=1 after release.
REQ-030 Reset asserted mid-transaction discards any pending response; storage contents are not cleared by reset.
REQ-031 Storage is zero-initialised at simulation start only.

Structure
REQ-032 Shared package mem_pkg holds the resp_err encoding (OK=2'b00, MISALIGNED=2'b01, DECODE_MISS=2'b10) and a log2 helper function.
REQ-033 Storage is a sub-module mem_byte_array with a synchronous byte-enabled write and an asynchronous read; the handshake, decode and response logic sit in data_mem_param.

Verification
REQ-034 Defaults: write 0x0000_0008 data 0xDEADBEEF be=4'hF, then read 0x0000_0008 -> read response rdata 0xDEADBEEF, err OK, each response one cycle after its accept.
REQ-035 Write 0x08 data 0x11223344 be=4'b0101 over 0xDEADBEEF, then read -> 0xDE22BE44.
REQ-036 Read 0x0000_0006 -> err MISALIGNED, rdata 0; read 0x0000_0080 -> err DECODE_MISS; storage unchanged after write attempts to both addresses.
REQ-037 Backpressure: hold resp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0 and response held stable; then resp_ready=1 -> one request accepted per cycle, responses in order.
REQ-038 Assert reset_n=0 while FULL -> resp_valid drops immediately; after release, previously written data still reads back.
REQ-039 Parameter set DATA_W=64, DEPTH=16, BASE_ADDR=32'h0000_1000: write 0x1078 be=8'hFF, read it back OK; read 0x1080 -> DECODE_MISS; read 0x1004 -> MISALIGNED.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the parameterised data memory: response status
// encoding, response-register states and a ceil-log2 helper.
package mem_pkg;

    localparam logic [1:0] ERR_OK          = 2'b00;
    localparam logic [1:0] ERR_MISALIGNED  = 2'b01;
    localparam logic [1:0] ERR_DECODE_MISS = 2'b10;

    typedef enum logic {
        StEmpty,
        StFull
    } resp_state_e;

    // Ceiling log2; log2(1) = 0, log2(2) = 1, log2(32) = 5.
    function automatic int unsigned log2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned r = 0; r < 32; r++) begin
            if ((64'd1 << r) < 64'(value)) begin
                result = r + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Word-organised storage with a synchronous byte-enabled write port and an
// asynchronous read port. Storage has no reset so contents survive reset_n.
module mem_byte_array
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 32,
    localparam int unsigned NB    = DATA_W / 8,
    localparam int unsigned IDX_W = log2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [NB-1:0]     be_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Update only the enabled byte lanes of the addressed word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (be_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_param.sv
// Single-port data memory behind a valid/ready request channel and a
// one-entry response register. Decodes a DEPTH-word window at BASE_ADDR,
// flags misaligned and out-of-window accesses, and answers every accepted
// request exactly one cycle later, in order.
module data_mem_param
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic [1:0]            resp_err
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFS   = log2(NB);
    localparam int unsigned IDX_W = log2(DEPTH);
    // Byte-offset bits, and offset+index bits (the whole decoded window).
    localparam logic [31:0] OFS_MASK    = 32'(NB - 1);
    localparam logic [31:0] REGION_MASK = 32'(DEPTH * NB - 1);

    logic [IDX_W-1:0]  idx;
    logic              misaligned;
    logic              hit;
    logic [1:0]        status;
    logic              accept;
    logic              wr_en;
    logic [DATA_W-1:0] rd_word;

    resp_state_e       state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        err_q, err_d;

    assign idx = IDX_W'(req_addr >> OFS);

    // Address decode; misalignment outranks a window miss.
    always_comb begin
        misaligned = (req_addr & OFS_MASK) != 32'd0;
        hit        = (req_addr & ~REGION_MASK) == (BASE_ADDR & ~REGION_MASK);
        if (misaligned) begin
            status = ERR_MISALIGNED;
        end else if (!hit) begin
            status = ERR_DECODE_MISS;
        end else begin
            status = ERR_OK;
        end
    end

    assign accept = req_valid && req_ready;
    assign wr_en  = accept && req_write && (status == ERR_OK);

    mem_byte_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_en),
        .be_i    (req_be),
        .waddr_i (idx),
        .wdata_i (req_wdata),
        .raddr_i (idx),
        .rdata_o (rd_word)
    );

    // Response register state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: fill on accept, drain when consumed without a refill.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (accept) state_d = StFull;
            StFull:  if (resp_ready && !accept) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    // Response payload captured on accept; reads see storage before the edge.
    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            err_d   = status;
            rdata_d = (!req_write && status == ERR_OK) ? rd_word : '0;
        end
    end

    // Response payload register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
            err_q   <= ERR_OK;
        end else begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs; req_ready depends only on state and resp_ready.
    always_comb begin
        resp_valid = (state_q == StFull);
        req_ready  = (state_q == StEmpty) || resp_ready;
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

endmodule

// File: tb/tb_data_mem_param.sv
// Bench for data_mem_param: default instance (32b x 32 at 0x0) and a
// 64b x 16 instance at 0x1000, checked against a byte-addressed model.
module tb_data_mem_param;
    import mem_pkg::*;

    localparam int unsigned A_DEPTH = 32;
    localparam int unsigned B_DEPTH = 16;
    localparam logic [31:0] B_BASE  = 32'h0000_1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic        a_req_valid, a_req_ready, a_req_write;
    logic [31:0] a_req_addr, a_req_wdata;
    logic [3:0]  a_req_be;
    logic        a_resp_valid, a_resp_ready;
    logic [31:0] a_resp_rdata;
    logic [1:0]  a_resp_err;

    logic        b_req_valid, b_req_ready, b_req_write;
    logic [31:0] b_req_addr;
    logic [63:0] b_req_wdata;
    logic [7:0]  b_req_be;
    logic        b_resp_valid, b_resp_ready;
    logic [63:0] b_resp_rdata;
    logic [1:0]  b_resp_err;

    data_mem_param u_dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (a_req_valid),
        .req_ready  (a_req_ready),
        .req_write  (a_req_write),
        .req_addr   (a_req_addr),
        .req_wdata  (a_req_wdata),
        .req_be     (a_req_be),
        .resp_valid (a_resp_valid),
        .resp_ready (a_resp_ready),
        .resp_rdata (a_resp_rdata),
        .resp_err   (a_resp_err)
    );

    data_mem_param #(
        .DATA_W    (64),
        .DEPTH     (B_DEPTH),
        .BASE_ADDR (B_BASE)
    ) u_dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .req_write  (b_req_write),
        .req_addr   (b_req_addr),
        .req_wdata  (b_req_wdata),
        .req_be     (b_req_be),
        .resp_valid (b_resp_valid),
        .resp_ready (b_resp_ready),
        .resp_rdata (b_resp_rdata),
        .resp_err   (b_resp_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: flat byte memories indexed by byte offset from the base.
    logic [7:0] mdl_a [A_DEPTH*4];
    logic [7:0] mdl_b [B_DEPTH*8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_a(input logic w, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] be, output logic [31:0] rd, output logic [1:0] err);
        longint unsigned a;
        a  = longint'(addr);
        rd = '0;
        if (a % 4 != 0) err = ERR_MISALIGNED;
        else if (a >= A_DEPTH * 4) err = ERR_DECODE_MISS;
        else begin
            err = ERR_OK;
            for (int b = 0; b < 4; b++) begin
                if (w) begin
                    if (be[b]) mdl_a[int'(a) + b] = wd[8*b +: 8];
                end else begin
                    rd[8*b +: 8] = mdl_a[int'(a) + b];
                end
            end
        end
    endtask

    task automatic model_b(input logic w, input logic [31:0] addr, input logic [63:0] wd,
                           input logic [7:0] be, output logic [63:0] rd, output logic [1:0] err);
        longint a;
        a  = longint'(addr) - longint'(B_BASE);
        rd = '0;
        if (addr % 8 != 0) err = ERR_MISALIGNED;
        else if (a < 0 || a >= B_DEPTH * 8) err = ERR_DECODE_MISS;
        else begin
            err = ERR_OK;
            for (int b = 0; b < 8; b++) begin
                if (w) begin
                    if (be[b]) mdl_b[int'(a) + b] = wd[8*b +: 8];
                end else begin
                    rd[8*b +: 8] = mdl_b[int'(a) + b];
                end
            end
        end
    endtask

    // Issue one request at posedge+1, then check its response one cycle on.
    task automatic req_a(input logic w, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input string tag);
        logic [31:0] exp_rd;
        logic [1:0]  exp_err;
        model_a(w, addr, wd, be, exp_rd, exp_err);
        a_req_valid = 1'b1;
        a_req_write = w;
        a_req_addr  = addr;
        a_req_wdata = wd;
        a_req_be    = be;
        #1;
        check({tag, "_ready"}, 64'(a_req_ready), 64'd1);
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        check({tag, "_valid"}, 64'(a_resp_valid), 64'd1);
        check({tag, "_rdata"}, 64'(a_resp_rdata), 64'(exp_rd));
        check({tag, "_err"}, 64'(a_resp_err), 64'(exp_err));
    endtask

    task automatic req_b(input logic w, input logic [31:0] addr, input logic [63:0] wd,
                         input logic [7:0] be, input string tag);
        logic [63:0] exp_rd;
        logic [1:0]  exp_err;
        model_b(w, addr, wd, be, exp_rd, exp_err);
        b_req_valid = 1'b1;
        b_req_write = w;
        b_req_addr  = addr;
        b_req_wdata = wd;
        b_req_be    = be;
        #1;
        check({tag, "_ready"}, 64'(b_req_ready), 64'd1);
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
        check({tag, "_valid"}, 64'(b_resp_valid), 64'd1);
        check({tag, "_rdata"}, b_resp_rdata, exp_rd);
        check({tag, "_err"}, 64'(b_resp_err), 64'(exp_err));
    endtask

    logic [31:0] e_rd;
    logic [1:0]  e_err;
    logic [31:0] r_addr;

    initial begin
        reset_n      = 1'b0;
        a_req_valid  = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0;
        a_req_be     = '0;   a_resp_ready = 1'b1;
        b_req_valid  = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        b_req_be     = '0;   b_resp_ready = 1'b1;
        foreach (mdl_a[i]) mdl_a[i] = 8'h00;
        foreach (mdl_b[i]) mdl_b[i] = 8'h00;

        #1;
        check("rst_valid", 64'(a_resp_valid), 64'd0);
        check("rst_rdata", 64'(a_resp_rdata), 64'd0);
        check("rst_err", 64'(a_resp_err), 64'(ERR_OK));
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check("rst_ready", 64'(a_req_ready), 64'd1);
        @(posedge clk);
        #1;

        // Give every word a known value so no power-up contents are assumed.
        for (int i = 0; i < int'(A_DEPTH); i++) req_a(1'b1, 32'(i * 4), $urandom, 4'hF, "fill_a");
        for (int i = 0; i < int'(B_DEPTH); i++)
            req_b(1'b1, B_BASE + 32'(i * 8), {$urandom, $urandom}, 8'hFF, "fill_b");

        // Full write, read back, partial-byte overwrite.
        req_a(1'b1, 32'h08, 32'hDEAD_BEEF, 4'hF, "wr_full");
        req_a(1'b0, 32'h08, 32'h0, 4'h0, "rd_full");
        req_a(1'b1, 32'h08, 32'h1122_3344, 4'b0101, "wr_part");
        req_a(1'b0, 32'h08, 32'h0, 4'h0, "rd_part");
        check("rd_part_const", 64'(a_resp_rdata), 64'h0000_0000_DE22_BE44);
        req_a(1'b1, 32'h08, 32'hFFFF_FFFF, 4'h0, "wr_be0");

        // Error statuses; writes with errors must leave storage untouched.
        req_a(1'b0, 32'h06, 32'h0, 4'h0, "rd_mis");
        req_a(1'b0, 32'h80, 32'h0, 4'h0, "rd_miss");
        req_a(1'b1, 32'h06, 32'h0BAD_0BAD, 4'hF, "wr_mis");
        req_a(1'b1, 32'h80, 32'h0BAD_0BAD, 4'hF, "wr_miss");
        req_a(1'b1, 32'h0A, 32'h0BAD_0BAD, 4'hF, "wr_mis2");
        req_a(1'b0, 32'h08, 32'h0, 4'h0, "rd_after_err");
        check("rd_after_err_const", 64'(a_resp_rdata), 64'h0000_0000_DE22_BE44);
        req_a(1'b0, 32'h00, 32'h0, 4'h0, "rd_word0");

        // Backpressure: drain, accept a write, then stall a pending read.
        @(posedge clk);
        #1;
        a_resp_ready = 1'b0;
        model_a(1'b1, 32'h0C, 32'hCAFE_F00D, 4'hF, e_rd, e_err);
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h0C;
        a_req_wdata = 32'hCAFE_F00D; a_req_be = 4'hF;
        @(posedge clk);
        #1;
        a_req_write = 1'b0; a_req_addr = 32'h0C; a_req_wdata = '0; a_req_be = '0;
        for (int i = 0; i < 3; i++) begin
            check("bp_ready", 64'(a_req_ready), 64'd0);
            check("bp_valid", 64'(a_resp_valid), 64'd1);
            check("bp_rdata", 64'(a_resp_rdata), 64'(e_rd));
            check("bp_err", 64'(a_resp_err), 64'(e_err));
            @(posedge clk);
            #1;
        end
        a_resp_ready = 1'b1;
        req_a(1'b0, 32'h0C, 32'h0, 4'h0, "bp_rd1");
        req_a(1'b0, 32'h08, 32'h0, 4'h0, "bp_rd2");
        req_a(1'b0, 32'h0C, 32'h0, 4'h0, "bp_rd3");

        // Reset while a response is pending; storage must survive.
        @(posedge clk);
        #1;
        a_resp_ready = 1'b0;
        req_a(1'b1, 32'h14, 32'h5A5A_1234, 4'hF, "rst_wr");
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_valid", 64'(a_resp_valid), 64'd0);
        check("midrst_rdata", 64'(a_resp_rdata), 64'd0);
        check("midrst_err", 64'(a_resp_err), 64'(ERR_OK));
        @(posedge clk);
        #1;
        reset_n      = 1'b1;
        a_resp_ready = 1'b1;
        #1;
        check("midrst_ready", 64'(a_req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_a(1'b0, 32'h14, 32'h0, 4'h0, "post_rst_rd1");
        req_a(1'b0, 32'h08, 32'h0, 4'h0, "post_rst_rd2");

        // Randomised traffic on the default instance.
        for (int n = 0; n < 150; n++) begin
            int unsigned kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) r_addr = 32'($urandom_range(0, A_DEPTH - 1) * 4 + $urandom_range(1, 3));
            else if (kind == 1) r_addr = 32'($urandom_range(A_DEPTH, 4000) * 4);
            else r_addr = 32'($urandom_range(0, A_DEPTH - 1) * 4);
            req_a(1'($urandom_range(0, 1)), r_addr, $urandom, 4'($urandom_range(0, 15)), "rnd_a");
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        // Wide instance at a non-zero base.
        req_b(1'b1, 32'h1078, 64'h0123_4567_89AB_CDEF, 8'hFF, "b_wr");
        req_b(1'b0, 32'h1078, 64'h0, 8'h00, "b_rd");
        check("b_rd_const", b_resp_rdata, 64'h0123_4567_89AB_CDEF);
        req_b(1'b0, 32'h1080, 64'h0, 8'h00, "b_miss");
        req_b(1'b0, 32'h1004, 64'h0, 8'h00, "b_mis");
        req_b(1'b0, 32'h0FF8, 64'h0, 8'h00, "b_below");
        for (int n = 0; n < 60; n++) begin
            int unsigned kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) r_addr = B_BASE + 32'($urandom_range(0, 127) | 1);
            else if (kind == 1) r_addr = 32'($urandom_range(0, 2000) * 8);
            else r_addr = B_BASE + 32'($urandom_range(0, B_DEPTH - 1) * 8);
            req_b(1'($urandom_range(0, 1)), r_addr, {$urandom, $urandom},
                  8'($urandom_range(0, 255)), "rnd_b");
        end

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
